// File: rtl/artyz7_output_pattern_pkg.sv
// Shared types and helpers for the artyz7 output pattern generator.
// Holds mode/state encodings and the variable left-rotate function.
package artyz7_output_pattern_pkg;

  // Upper bound on NUM_OUTPUTS supported by rotate_left.
  localparam int MAX_OUT = 256;

  typedef enum logic [1:0] {
    MODE_REPLICATE = 2'd0,
    MODE_ROTATE    = 2'd1,
    MODE_WALK      = 2'd2,
    MODE_HOLD      = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  // Rotate the low `width` bits of vector left by amount
  // (amount < width). Bits at and above width come back 0.
  function automatic logic [MAX_OUT-1:0] rotate_left(
    input logic [MAX_OUT-1:0] vector,
    input int                 width,
    input int                 amount
  );
    logic [MAX_OUT-1:0] res;
    int j;
    res = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (i < width) begin
        j = i + amount;
        if (j >= width) j = j - width;
        res[j] = vector[i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/artyz7_tick_prescaler.sv
// Programmable tick prescaler: pulses tick when cnt reaches prescale.
// Ports: clk_ext, reset_n, clear (hold cnt at 0, mute tick), prescale, tick.
module artyz7_tick_prescaler #(
  parameter int PRESCALE_WIDTH = 24
) (
  input  logic                      clk_ext,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] cnt;

  // >= so a prescale lowered below cnt ends the period at once.
  assign tick = !clear && (cnt >= prescale);

  always_ff @(posedge clk_ext or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/artyz7_output_pattern_gen.sv
// Maps synchronised led inputs onto a registered dummy_output bank.
// Ports: clk_ext, reset_n, led, prescale, mode/valid/ready, tick, dummy_output.
module artyz7_output_pattern_gen
  import artyz7_output_pattern_pkg::*;
#(
  parameter int NUM_LEDS       = 4,
  parameter int NUM_OUTPUTS    = 22,
  parameter int PRESCALE_WIDTH = 24
) (
  input  logic                      clk_ext,
  input  logic                      reset_n,
  input  logic [NUM_LEDS-1:0]       led,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [1:0]                mode,
  input  logic                      mode_valid,
  output logic                      mode_ready,
  output logic                      tick,
  output logic [NUM_OUTPUTS-1:0]    dummy_output
);

  localparam int RW =
    (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam logic [RW-1:0] ROT_MAX = RW'(NUM_OUTPUTS - 1);

  state_t state, state_n;
  mode_t  mode_q, mode_n;

  logic [NUM_LEDS-1:0]    led_m, led_s;
  logic [RW-1:0]          rot_idx, rot_n;
  logic [NUM_OUTPUTS-1:0] out_q, out_n;
  logic [NUM_OUTPUTS-1:0] base, rotated, walk, pattern;
  logic [MAX_OUT-1:0]     rot_full;
  logic                   ready_q, accept, clear;

  assign mode_ready   = ready_q;
  assign dummy_output = out_q;
  assign clear        = (state != ST_RUN);

  artyz7_tick_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk_ext (clk_ext),
    .reset_n (reset_n),
    .clear   (clear),
    .prescale(prescale),
    .tick    (tick)
  );

  always_ff @(posedge clk_ext or negedge reset_n) begin
    if (!reset_n) begin
      led_m <= '0;
      led_s <= '0;
    end else begin
      led_m <= led;
      led_s <= led_m;
    end
  end

  always_comb begin
    base = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      base[i] = led_s[i % NUM_LEDS];
    end
  end

  assign rot_full = rotate_left(MAX_OUT'(base),
                                NUM_OUTPUTS,
                                int'(rot_idx));
  assign rotated  = rot_full[NUM_OUTPUTS-1:0];

  always_comb begin
    walk          = '0;
    walk[rot_idx] = |led_s;
  end

  always_comb begin
    pattern = out_q;
    unique case (mode_q)
      MODE_REPLICATE: pattern = base;
      MODE_ROTATE:    pattern = rotated;
      MODE_WALK:      pattern = walk;
      MODE_HOLD:      pattern = out_q;
      default:        pattern = out_q;
    endcase
  end

  always_ff @(posedge clk_ext or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_INIT;
      mode_q  <= MODE_REPLICATE;
      rot_idx <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      mode_q  <= mode_n;
      rot_idx <= rot_n;
      out_q   <= out_n;
      // Ready mirrors "next cycle is RUN": low through SWITCH.
      ready_q <= (state_n == ST_RUN);
    end
  end

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    rot_n   = rot_idx;
    out_n   = out_q;
    accept  = 1'b0;
    unique case (state)
      ST_INIT: begin
        state_n = ST_RUN;
        out_n   = pattern;
      end
      ST_RUN: begin
        out_n  = pattern;
        accept = mode_valid && ready_q;
        if (accept) begin
          // Accept beats a coincident tick; SWITCH clears rot_idx.
          state_n = ST_SWITCH;
          mode_n  = mode_t'(mode);
        end else if (tick &&
                     (mode_q == MODE_ROTATE ||
                      mode_q == MODE_WALK)) begin
          rot_n = (rot_idx == ROT_MAX) ?
                  '0 : rot_idx + RW'(1);
        end
      end
      ST_SWITCH: begin
        state_n = ST_RUN;
        rot_n   = '0;
      end
      default: begin
        state_n = ST_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_artyz7_output_pattern_gen.sv
// Directed bench for artyz7_output_pattern_gen (4 leds, 22 outputs).
// Expected outputs go through a queue and are popped at check time.
module tb_artyz7_output_pattern_gen;

  logic        clk_ext;
  logic        reset_n;
  logic [3:0]  led;
  logic [23:0] prescale;
  logic [1:0]  mode;
  logic        mode_valid;
  logic        mode_ready;
  logic        tick;
  logic [21:0] dummy_output;

  int tests;
  int fails;
  int cyc;

  logic [21:0] exp_q[$];

  artyz7_output_pattern_gen #(
    .NUM_LEDS      (4),
    .NUM_OUTPUTS   (22),
    .PRESCALE_WIDTH(24)
  ) dut (
    .clk_ext     (clk_ext),
    .reset_n     (reset_n),
    .led         (led),
    .prescale    (prescale),
    .mode        (mode),
    .mode_valid  (mode_valid),
    .mode_ready  (mode_ready),
    .tick        (tick),
    .dummy_output(dummy_output)
  );

  initial clk_ext = 1'b0;
  always #5 clk_ext = ~clk_ext;

  always @(posedge clk_ext) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_ext);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] rotl(
    input logic [21:0] v, input int k);
    logic [43:0] t;
    t = {v, v} << k;
    return t[43:22];
  endfunction

  initial begin
    logic [21:0] hold_v;
    int nt, acc, last, w, nticks;
    logic saw;

    tests = 0;
    fails = 0;
    cyc   = 0;
    reset_n    = 1'b0;
    led        = 4'b0000;
    prescale   = 24'd0;
    mode       = 2'd0;
    mode_valid = 1'b0;

    // reset state
    repeat (3) step();
    chk("rst_out", dummy_output, 0);
    chk("rst_tick", tick, 0);
    chk("rst_ready", mode_ready, 0);

    // release, replicate 0101
    reset_n = 1'b1;
    led     = 4'b0101;
    chk("init_ready", mode_ready, 0);
    step();
    chk("run_ready", mode_ready, 1);
    chk("lat1_out", dummy_output, 0);
    chk("ps0_tick1", tick, 1);
    step();
    chk("lat2_out", dummy_output, 0);
    chk("ps0_tick2", tick, 1);
    step();
    chk("rep_out", dummy_output, 22'h155555);

    // rotate, prescale 3
    prescale   = 24'd3;
    led        = 4'b0001;
    mode       = 2'd1;
    mode_valid = 1'b1;
    step();
    mode_valid = 1'b0;
    chk("acc_ready0", mode_ready, 0);
    chk("sw_tick0", tick, 0);
    step();
    chk("sw_hold_out", dummy_output, 22'h155555);
    step();
    chk("rot0_out", dummy_output, 22'h111111);
    last = 0;
    for (int k = 1; k <= 22; k++) begin
      w = 0;
      while (!tick && w < 8) begin
        step();
        w++;
      end
      if (!tick) begin
        chk("rot_tick_timeout", 0, 1);
        break;
      end
      if (k > 1) chk("rot_tick_gap", cyc - last, 4);
      last = cyc;
      exp_q.push_back(rotl(22'h111111, k % 22));
      step();
      step();
      chk("rot_out", dummy_output, exp_q.pop_front());
    end

    // walk, prescale 0
    prescale   = 24'd0;
    mode       = 2'd2;
    mode_valid = 1'b1;
    step();
    mode_valid = 1'b0;
    chk("walk_acc_ready", mode_ready, 0);
    step();
    chk("walk_run_ready", mode_ready, 1);
    for (int k = 0; k < 22; k++)
      exp_q.push_back(22'(1) << k);
    exp_q.push_back(22'h000001);
    while (exp_q.size() > 0) begin
      step();
      chk("walk_out", dummy_output, exp_q.pop_front());
    end
    led = 4'b0000;
    step();
    step();
    chk("walk_lag_nz", |dummy_output, 1);
    step();
    chk("walk_zero", dummy_output, 0);

    // held valid, alternating mode
    led        = 4'b0101;
    mode       = 2'd1;
    mode_valid = 1'b1;
    acc        = 0;
    for (int i = 0; i < 12; i++) begin
      chk("alt_ready", mode_ready, (i % 2 == 0) ? 1 : 0);
      saw = mode_ready;
      step();
      if (saw) begin
        acc++;
        mode = (mode == 2'd1) ? 2'd0 : 2'd1;
      end
    end
    mode_valid = 1'b0;
    chk("alt_accepts", acc, 6);
    step();
    step();
    step();
    chk("alt_last_mode", dummy_output, 22'h155555);

    // hold entered mid-rotation
    led        = 4'b0001;
    prescale   = 24'd1;
    mode       = 2'd1;
    mode_valid = 1'b1;
    step();
    mode_valid = 1'b0;
    step();
    nt = 0;
    repeat (7) begin
      if (tick) nt++;
      step();
    end
    chk("mid_rot_ticks", nt, 3);
    mode       = 2'd3;
    mode_valid = 1'b1;
    step();
    mode_valid = 1'b0;
    hold_v = rotl(22'h111111, nt);
    chk("hold_entry", dummy_output, hold_v);
    led    = 4'b1110;
    nticks = 0;
    repeat (6) begin
      step();
      if (tick) nticks++;
      chk("hold_out", dummy_output, hold_v);
    end
    chk("hold_ticks", (nticks > 0) ? 1 : 0, 1);

    // reset while in SWITCH
    mode       = 2'd2;
    mode_valid = 1'b1;
    step();
    chk("pre_rst_ready", mode_ready, 0);
    reset_n = 1'b0;
    #1;
    chk("arst_out", dummy_output, 0);
    chk("arst_ready", mode_ready, 0);
    chk("arst_tick", tick, 0);
    mode_valid = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    led     = 4'b0101;
    repeat (4) step();
    chk("post_rst_mode", dummy_output, 22'h155555);
    chk("post_rst_ready", mode_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
